// File: rtl/sync_pkg.sv
// Shared helpers for Gray-coded pointer synchronisation in the async FIFO.
package sync_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  // Widest pointer the helpers handle; narrower pointers are zero-extended.
  localparam int unsigned PTR_MAX_W       = 64;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
  // Zero-extension leaves the low bits of the result unaffected.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray, shared with the pointer generators.
  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Parametrised N-stage synchroniser flop chain, usable for single- or multi-bit data.
module sync_chain
  import sync_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < SYNC_STAGES_MIN) begin : g_stages_chk
    $error("sync_chain: STAGES must be at least %0d", SYNC_STAGES_MIN);
  end

  logic [WIDTH-1:0] stage [STAGES];

  // Plain flop-to-flop chain with no logic between stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/sync_gray_ptr.sv
// Gray pointer synchroniser with registered binary decode, advance delta and
// warm-up valid. Optional Gray-violation check enabled by SYNC_GRAY_CHECK_EN.
module sync_gray_ptr
  import sync_pkg::*;
#(
  parameter int unsigned PTR_WIDTH   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [PTR_WIDTH-1:0] gptr_in,
  output logic [PTR_WIDTH-1:0] rq_gray,
  output logic [PTR_WIDTH-1:0] rq_bin,
  output logic [PTR_WIDTH-1:0] rq_delta,
  output logic                 rq_valid,
  output logic                 rq_err
);

  localparam int unsigned WARM_MAX = SYNC_STAGES + 1;
  localparam int unsigned WARM_W   = $clog2(SYNC_STAGES + 2);

  if (PTR_WIDTH < 2 || PTR_WIDTH > PTR_MAX_W) begin : g_width_chk
    $error("sync_gray_ptr: PTR_WIDTH must be in 2..%0d", PTR_MAX_W);
  end

  logic [PTR_WIDTH-1:0] bin_next;
  logic [PTR_WIDTH-1:0] delta_next;
  logic [WARM_W-1:0]    warm_cnt;

  // Foreign-domain pointer capture.
  sync_chain #(
    .WIDTH  (PTR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_chain (
    .clk (rclk),
    .rst (rrst),
    .d   (gptr_in),
    .q   (rq_gray)
  );

  // rq_bin still holds the previous decode, so it serves as the delta reference.
  assign bin_next   = PTR_WIDTH'(gray2bin(PTR_MAX_W'(rq_gray)));
  assign delta_next = bin_next - rq_bin;

  // Warm-up counter saturating once the chain and decode stage are flushed.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      warm_cnt <= '0;
      rq_valid <= 1'b0;
    end else begin
      if (warm_cnt != WARM_W'(WARM_MAX)) begin
        warm_cnt <= warm_cnt + WARM_W'(1);
      end
      rq_valid <= (warm_cnt >= WARM_W'(SYNC_STAGES));
    end
  end

  // Decode and delta; delta is suppressed until rq_bin holds a real sample.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rq_bin   <= '0;
      rq_delta <= '0;
    end else begin
      rq_bin   <= bin_next;
      rq_delta <= rq_valid ? delta_next : '0;
    end
  end

`ifdef SYNC_GRAY_CHECK_EN
  logic [PTR_WIDTH-1:0] gray_prev;
  logic                 multi_hop;

  // The previous rq_gray is recovered from rq_bin rather than stored again.
  assign gray_prev = PTR_WIDTH'(bin2gray(PTR_MAX_W'(rq_bin)));
  assign multi_hop = ($countones(rq_gray ^ gray_prev) > 1);

  // One-cycle pulse when more than one Gray bit moved in a cycle.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rq_err <= 1'b0;
    end else begin
      rq_err <= rq_valid && multi_hop;
    end
  end

`ifndef SYNTHESIS
  // Simulation-only report of the same violation.
  always @(posedge rclk) begin
    if (!rrst && rq_valid && multi_hop) begin
      $error("sync_gray_ptr: Gray violation, rq_gray=%h prev=%h", rq_gray, gray_prev);
    end
  end
`endif
`else
  assign rq_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_gray_ptr.sv
// Directed bench for sync_gray_ptr at SYNC_STAGES=2 and SYNC_STAGES=3 (PTR_WIDTH=4),
// checked every cycle against an input-history model plus literal expectations.
module tb_sync_gray_ptr;

  logic       clk = 1'b0;
  logic       rrst;
  logic [3:0] gptr_in;

  logic [3:0] g2, b2, dl2;
  logic       v2, e2;
  logic [3:0] g3, b3, dl3;
  logic       v3, e3;

  int tests = 0;
  int fails = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  sync_gray_ptr #(.PTR_WIDTH(4), .SYNC_STAGES(2)) dut2 (
    .rclk(clk), .rrst(rrst), .gptr_in(gptr_in),
    .rq_gray(g2), .rq_bin(b2), .rq_delta(dl2), .rq_valid(v2), .rq_err(e2)
  );

  sync_gray_ptr #(.PTR_WIDTH(4), .SYNC_STAGES(3)) dut3 (
    .rclk(clk), .rrst(rrst), .gptr_in(gptr_in),
    .rq_gray(g3), .rq_bin(b3), .rq_delta(dl3), .rq_valid(v3), .rq_err(e3)
  );

  // Input history as seen at each rising edge.
  logic [3:0] gin_h [0:255];
  int n_edge   = 0;
  int last_rst = -1;

  always @(posedge clk) begin
    if (n_edge < 256) begin
      gin_h[n_edge] = gptr_in;
      if (rrst) last_rst = n_edge;
      n_edge++;
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Binary bit i is the parity of Gray bits i and above.
  function automatic logic [3:0] g2b_m(input logic [3:0] g);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [3:0] b2g_m(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Expected outputs after the latest edge, from edges-since-reset and input history.
  task automatic model_check(input string tag, input int s,
                             input logic [3:0] ag, input logic [3:0] ab,
                             input logic [3:0] ad, input logic av, input logic ae);
    int n, k;
    logic [3:0] eg, eb, ed;
    logic ev, ee;
    n  = n_edge - 1;
    k  = n - last_rst;
    eg = (k >= s) ? gin_h[n-s+1] : 4'h0;
    eb = (k >= s + 1) ? g2b_m(gin_h[n-s]) : 4'h0;
    ev = (k >= s + 1);
    ed = (k >= s + 2) ? 4'(g2b_m(gin_h[n-s]) - g2b_m(gin_h[n-s-1])) : 4'h0;
`ifdef SYNC_GRAY_CHECK_EN
    ee = (k >= s + 2) && ($countones(gin_h[n-s] ^ gin_h[n-s-1]) > 1);
`else
    ee = 1'b0;
`endif
    chk({tag, "_gray"},  ag, eg);
    chk({tag, "_bin"},   ab, eb);
    chk({tag, "_delta"}, ad, ed);
    chk({tag, "_valid"}, 4'(av), 4'(ev));
    chk({tag, "_err"},   4'(ae), 4'(ee));
  endtask

  always @(negedge clk) begin
    if (run_chk && last_rst >= 0 && n_edge < 256) begin
      model_check("m2", 2, g2, b2, dl2, v2, e2);
      model_check("m3", 3, g3, b3, dl3, v3, e3);
    end
  end

  // Apply inputs, let one rising edge happen, return at the following falling edge.
  task automatic cyc(input logic [3:0] g, input logic r);
    gptr_in = g;
    rrst    = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic exp_err5;

  initial begin
    rrst    = 1'b1;
    gptr_in = 4'h0;
    run_chk = 1'b1;
`ifdef SYNC_GRAY_CHECK_EN
    exp_err5 = 1'b1;
`else
    exp_err5 = 1'b0;
`endif

    // Reset flush
    repeat (3) cyc(4'h0, 1'b1);
    chk("rst_gray",  g2, 4'h0);
    chk("rst_bin",   b2, 4'h0);
    chk("rst_delta", dl2, 4'h0);
    chk("rst_valid", 4'(v2), 4'h0);
    chk("rst_err",   4'(e2), 4'h0);
    cyc(4'h0, 1'b0); chk("warm1_valid", 4'(v2), 4'h0);
    cyc(4'h0, 1'b0); chk("warm2_valid", 4'(v2), 4'h0);
    cyc(4'h0, 1'b0); chk("warm3_valid", 4'(v2), 4'h1);
    chk("warm3_delta", dl2, 4'h0);
    chk("warm3_valid_s3", 4'(v3), 4'h0);
    cyc(4'h0, 1'b0); chk("warm4_valid_s3", 4'(v3), 4'h1);
    cyc(4'h0, 1'b0);

    // Latency
    cyc(4'h1, 1'b0); chk("lat1_gray", g2, 4'h0);
    cyc(4'h1, 1'b0); chk("lat2_gray", g2, 4'h1); chk("lat2_bin", b2, 4'h0);
    cyc(4'h1, 1'b0); chk("lat3_bin", b2, 4'h1);  chk("lat3_delta", dl2, 4'h1);
    cyc(4'h1, 1'b0); chk("lat4_delta", dl2, 4'h0); chk("lat4_bin", b2, 4'h1);
    chk("lat4_bin_s3", b3, 4'h1); chk("lat4_delta_s3", dl3, 4'h1);

    // Gray sequence 0011, 0010, 0110
    cyc(4'h3, 1'b0);
    cyc(4'h2, 1'b0);
    cyc(4'h6, 1'b0); chk("seq_bin2", b2, 4'h2); chk("seq_delta2", dl2, 4'h1);
    cyc(4'h6, 1'b0); chk("seq_bin3", b2, 4'h3); chk("seq_delta3", dl2, 4'h1);
    cyc(4'h6, 1'b0); chk("seq_bin4", b2, 4'h4); chk("seq_delta4", dl2, 4'h1);
    chk("seq_err", 4'(e2), 4'h0);
    cyc(4'h6, 1'b0); chk("seq_hold_delta", dl2, 4'h0);

    // Walk up to 14, then wrap 14 -> 15 -> 0
    for (int b = 5; b <= 14; b++) cyc(b2g_m(4'(b)), 1'b0);
    cyc(4'b1001, 1'b0);
    cyc(4'b1001, 1'b0); chk("wrap_bin14", b2, 4'd14); chk("wrap_delta14", dl2, 4'h1);
    cyc(4'b1000, 1'b0);
    cyc(4'b1000, 1'b0);
    cyc(4'b1000, 1'b0); chk("wrap_bin15", b2, 4'd15); chk("wrap_delta15", dl2, 4'h1);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0); chk("wrap_bin0", b2, 4'h0); chk("wrap_delta0", dl2, 4'h1);
    chk("wrap_err", 4'(e2), 4'h0);
    cyc(4'b0000, 1'b0);

    // Two-bit Gray jump 0000 -> 0011
    cyc(4'h3, 1'b0);
    cyc(4'h3, 1'b0);
    cyc(4'h3, 1'b0); chk("jump_bin", b2, 4'h2); chk("jump_delta", dl2, 4'h2);
    chk("jump_err", 4'(e2), 4'(exp_err5));
    cyc(4'h3, 1'b0); chk("jump_err_after", 4'(e2), 4'h0); chk("jump_delta_after", dl2, 4'h0);

    // Mid-operation reset on the 3-stage instance holding 7
    cyc(4'b0010, 1'b0);
    cyc(4'b0110, 1'b0);
    cyc(4'b0111, 1'b0);
    cyc(4'b0101, 1'b0);
    cyc(4'b0100, 1'b0);
    repeat (3) cyc(4'b0100, 1'b0);
    chk("mrst_pre_bin_s3", b3, 4'h7);
    cyc(4'b0100, 1'b0);
    cyc(4'b0100, 1'b1);
    chk("mrst_bin_s3",   b3, 4'h0);
    chk("mrst_valid_s3", 4'(v3), 4'h0);
    chk("mrst_gray_s3",  g3, 4'h0);
    cyc(4'b0100, 1'b0); chk("mrst_w1_valid_s3", 4'(v3), 4'h0);
    cyc(4'b0100, 1'b0); chk("mrst_w2_valid_s3", 4'(v3), 4'h0);
    cyc(4'b0100, 1'b0); chk("mrst_w3_valid_s3", 4'(v3), 4'h0);
    chk("mrst_w3_delta_s3", dl3, 4'h0);
    cyc(4'b0100, 1'b0); chk("mrst_w4_valid_s3", 4'(v3), 4'h1);
    chk("mrst_w4_bin_s3", b3, 4'h7); chk("mrst_w4_delta_s3", dl3, 4'h0);
    cyc(4'b0100, 1'b0); chk("mrst_w5_delta_s3", dl3, 4'h0); chk("mrst_w5_bin_s3", b3, 4'h7);

    run_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
